// File: rtl/tcam_pkg.sv
// Shared TCAM constants and the log2 helper used to size address fields.
package tcam_pkg;

    localparam int TCAM_MAX_RULE_DEF = 64;
    localparam int TCAM_SEG_W_DEF    = 8;
    localparam int TCAM_MAX_RULE_MAX = 1024;

    // Ceiling log2; exact for the power-of-two widths used by the encoders.
    function automatic int tcam_log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_lowest.sv
// One segment of the encode tree: lowest set bit index plus an any-bit flag.
module seg_lowest
    import tcam_pkg::*;
#(
    parameter int SEG_W = TCAM_SEG_W_DEF,
    parameter int IDX_W = tcam_log2(TCAM_SEG_W_DEF)
) (
    input  logic [SEG_W-1:0] seg_vec,
    output logic             seg_any,
    output logic [IDX_W-1:0] seg_idx
);

    // Scan high to low so the lowest set bit is the last one to win.
    always_comb begin
        seg_any = |seg_vec;
        seg_idx = {IDX_W{1'b0}};
        for (int i = SEG_W - 1; i >= 0; i--) begin
            seg_idx = seg_vec[i] ? IDX_W'(i) : seg_idx;
        end
    end

endmodule

// File: rtl/pipe_priority_encoder.sv
// Two-stage priority encoder: a residual stage holding the vector still to be
// reported, and an output stage presenting one result per cycle. In all_mode
// the residual stage walks through every set bit, lowest first.
module pipe_priority_encoder
    import tcam_pkg::*;
#(
    parameter  int MAX_RULE = TCAM_MAX_RULE_DEF,
    parameter  int SEG_W    = TCAM_SEG_W_DEF,
    localparam int ADDR_W   = tcam_log2(MAX_RULE)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MAX_RULE-1:0] match_vec,
    input  logic                all_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                match,
    output logic [ADDR_W-1:0]   match_addr,
    output logic [ADDR_W:0]     match_cnt,
    output logic                match_last
);

    localparam int NSEG   = MAX_RULE / SEG_W;
    localparam int SEG_AW = (SEG_W > 1) ? tcam_log2(SEG_W) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    // Residual stage
    logic [MAX_RULE-1:0] r_res_vec;
    logic                r_res_mode;
    logic [CNT_W-1:0]    r_res_cnt;
    logic                r_res_valid;

    // Output stage
    logic                r_out_valid;
    logic                r_match;
    logic [ADDR_W-1:0]   r_match_addr;
    logic [CNT_W-1:0]    r_match_cnt;
    logic                r_match_last;

    logic [NSEG-1:0]     w_seg_any;
    logic [SEG_AW-1:0]   w_seg_idx [NSEG];
    logic [ADDR_W-1:0]   w_addr;
    logic                w_any;
    logic [MAX_RULE-1:0] w_res_clr;
    logic                w_last;
    logic                w_load;
    logic                w_in_ready;
    logic                w_accept;
    logic [CNT_W-1:0]    w_pop;

    // First encode level: one lowest-bit encoder per segment of the residual.
    for (genvar g = 0; g < NSEG; g++) begin : g_seg
        seg_lowest #(
            .SEG_W (SEG_W),
            .IDX_W (SEG_AW)
        ) u_seg_lowest (
            .seg_vec (r_res_vec[g*SEG_W +: SEG_W]),
            .seg_any (w_seg_any[g]),
            .seg_idx (w_seg_idx[g])
        );
    end

    // Second encode level: pick the lowest non-empty segment and splice its index.
    always_comb begin
        w_any  = |w_seg_any;
        w_addr = {ADDR_W{1'b0}};
        for (int s = NSEG - 1; s >= 0; s--) begin
            w_addr = w_seg_any[s] ? (ADDR_W'(s * SEG_W) + ADDR_W'(w_seg_idx[s])) : w_addr;
        end
    end

    // Popcount of the incoming vector, captured alongside it on accept.
    always_comb begin
        w_pop = {CNT_W{1'b0}};
        for (int i = 0; i < MAX_RULE; i++) begin
            w_pop = w_pop + CNT_W'(match_vec[i]);
        end
    end

    // Residual with its lowest bit removed; non-zero means more than one bit left.
    assign w_res_clr = r_res_vec & (r_res_vec - {{(MAX_RULE-1){1'b0}}, 1'b1});
    assign w_last    = !r_res_mode || !(|w_res_clr);

    // Output stage loads whenever it is empty or being drained this edge.
    assign w_load     = r_res_valid && (!r_out_valid || out_ready);
    assign w_in_ready = rst_n && (!r_res_valid || (w_load && w_last));
    assign w_accept   = in_valid && w_in_ready;

    // Residual stage: accept a new vector, or step through remaining bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_res_vec   <= {MAX_RULE{1'b0}};
            r_res_mode  <= 1'b0;
            r_res_cnt   <= {CNT_W{1'b0}};
            r_res_valid <= 1'b0;
        end else if (w_accept) begin
            r_res_vec   <= match_vec;
            r_res_mode  <= all_mode;
            r_res_cnt   <= w_pop;
            r_res_valid <= 1'b1;
        end else if (w_load) begin
            if (w_last) begin
                r_res_valid <= 1'b0;
            end else begin
                r_res_vec   <= w_res_clr;
                r_res_valid <= 1'b1;
            end
        end else begin
            r_res_valid <= r_res_valid;
        end
    end

    // Output stage: present one encoded result, hold it under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_match      <= 1'b0;
            r_match_addr <= {ADDR_W{1'b0}};
            r_match_cnt  <= {CNT_W{1'b0}};
            r_match_last <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_match      <= w_any;
            r_match_addr <= w_addr;
            r_match_cnt  <= r_res_cnt;
            r_match_last <= w_last;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end else begin
            r_out_valid  <= r_out_valid;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign match      = r_match;
    assign match_addr = r_match_addr;
    assign match_cnt  = r_match_cnt;
    assign match_last = r_match_last;

endmodule

// File: tb/tb_pipe_priority_encoder.sv
// Directed, table-driven bench for pipe_priority_encoder (64 rules, 8-bit segments).
module tb_pipe_priority_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] match_vec;
    logic        all_mode;
    logic        out_valid;
    logic        out_ready;
    logic        match;
    logic [5:0]  match_addr;
    logic [6:0]  match_cnt;
    logic        match_last;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [63:0] vec;
        logic        mode;
        logic        exp_match;
        logic [5:0]  exp_addr;
        logic [6:0]  exp_cnt;
    } vec_t;

    vec_t tbl [8];

    pipe_priority_encoder #(
        .MAX_RULE (64),
        .SEG_W    (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .match_vec  (match_vec),
        .all_mode   (all_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .match      (match),
        .match_addr (match_addr),
        .match_cnt  (match_cnt),
        .match_last (match_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One vector in, exactly one result two cycles later.
    task automatic apply_single(input string tag, input vec_t v);
        @(negedge clk);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        match_vec = v.vec;
        all_mode  = v.mode;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_match"}, 64'(match), 64'(v.exp_match));
        chk({tag, "_addr"}, 64'(match_addr), 64'(v.exp_addr));
        chk({tag, "_cnt"}, 64'(match_cnt), 64'(v.exp_cnt));
        chk({tag, "_last"}, 64'(match_last), 64'd1);
        @(negedge clk);
        chk({tag, "_one_result"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        vec_t v17;
        tbl[0] = '{64'h8000_0000_0000_0001, 1'b0, 1'b1, 6'd0,  7'd2};
        tbl[1] = '{64'h0000_0000_0000_0000, 1'b1, 1'b0, 6'd0,  7'd0};
        tbl[2] = '{64'h0000_0000_0000_0000, 1'b0, 1'b0, 6'd0,  7'd0};
        tbl[3] = '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 6'd63, 7'd1};
        tbl[4] = '{64'h0000_0000_0000_0100, 1'b1, 1'b1, 6'd8,  7'd1};
        tbl[5] = '{64'h0000_0000_0000_00F0, 1'b0, 1'b1, 6'd4,  7'd4};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 6'd0,  7'd64};
        tbl[7] = '{64'h0000_0000_0001_8000, 1'b0, 1'b1, 6'd15, 7'd2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        all_mode  = 1'b0;
        out_ready = 1'b1;
        match_vec = 64'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_match", 64'(match), 64'd0);
        chk("rst_addr", 64'(match_addr), 64'd0);
        chk("rst_cnt", 64'(match_cnt), 64'd0);
        chk("rst_last", 64'(match_last), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single-result vectors
        for (int i = 0; i < 8; i++) begin
            apply_single($sformatf("tbl%0d", i), tbl[i]);
        end

        // all_mode stream {3,40,63}
        @(negedge clk);
        chk("a_in_ready0", 64'(in_ready), 64'd1);
        in_valid = 1'b1; match_vec = 64'h8000_0100_0000_0008; all_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("a_t1_valid", 64'(out_valid), 64'd0);
        chk("a_t1_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("a_r0_valid", 64'(out_valid), 64'd1);
        chk("a_r0_addr", 64'(match_addr), 64'd3);
        chk("a_r0_cnt", 64'(match_cnt), 64'd3);
        chk("a_r0_last", 64'(match_last), 64'd0);
        chk("a_r0_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("a_r1_valid", 64'(out_valid), 64'd1);
        chk("a_r1_addr", 64'(match_addr), 64'd40);
        chk("a_r1_cnt", 64'(match_cnt), 64'd3);
        chk("a_r1_last", 64'(match_last), 64'd0);
        chk("a_r1_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("a_r2_valid", 64'(out_valid), 64'd1);
        chk("a_r2_addr", 64'(match_addr), 64'd63);
        chk("a_r2_cnt", 64'(match_cnt), 64'd3);
        chk("a_r2_last", 64'(match_last), 64'd1);
        @(negedge clk);
        chk("a_end_valid", 64'(out_valid), 64'd0);

        // Same stream with backpressure after the first result
        @(negedge clk);
        in_valid = 1'b1; match_vec = 64'h8000_0100_0000_0008; all_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("b_r0_addr", 64'(match_addr), 64'd3);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("b_hold%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("b_hold%0d_addr", i), 64'(match_addr), 64'd3);
            chk($sformatf("b_hold%0d_cnt", i), 64'(match_cnt), 64'd3);
            chk($sformatf("b_hold%0d_last", i), 64'(match_last), 64'd0);
            chk($sformatf("b_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("b_r1_valid", 64'(out_valid), 64'd1);
        chk("b_r1_addr", 64'(match_addr), 64'd40);
        @(negedge clk);
        chk("b_r2_addr", 64'(match_addr), 64'd63);
        chk("b_r2_last", 64'(match_last), 64'd1);
        @(negedge clk);
        chk("b_end_valid", 64'(out_valid), 64'd0);

        // Eight back-to-back single-mode vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk($sformatf("c%0d_valid", i - 2), 64'(out_valid), 64'd1);
                chk($sformatf("c%0d_addr", i - 2), 64'(match_addr), 64'((i - 2) * 8));
                chk($sformatf("c%0d_cnt", i - 2), 64'(match_cnt), 64'd1);
                chk($sformatf("c%0d_last", i - 2), 64'(match_last), 64'd1);
            end
            if (i < 8) begin
                chk($sformatf("c%0d_in_ready", i), 64'(in_ready), 64'd1);
                in_valid  = 1'b1;
                match_vec = 64'd1 << (i * 8);
                all_mode  = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("c_end_valid", 64'(out_valid), 64'd0);

        // Reset mid-stream, then a fresh vector
        @(negedge clk);
        in_valid = 1'b1; match_vec = 64'h8000_0100_0000_0008; all_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("d_r0_addr", 64'(match_addr), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("d_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("d_rst_valid", 64'(out_valid), 64'd0);
        chk("d_rst_addr", 64'(match_addr), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("d_quiet%0d_valid", i), 64'(out_valid), 64'd0);
        end
        v17 = '{64'h0000_0000_0002_0000, 1'b0, 1'b1, 6'd17, 7'd1};
        apply_single("d_fresh", v17);

        // All-ones in all_mode: 64 consecutive results
        @(negedge clk);
        in_valid = 1'b1; match_vec = 64'hFFFF_FFFF_FFFF_FFFF; all_mode = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk($sformatf("e%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("e%0d_addr", i), 64'(match_addr), 64'(i));
            chk($sformatf("e%0d_cnt", i), 64'(match_cnt), 64'd64);
            chk($sformatf("e%0d_last", i), 64'(match_last), 64'(i == 63));
        end
        @(negedge clk);
        chk("e_end_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
